multicycle_control_unit: RTL and testbench

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/multicycle_control_unit.sv | 199 +++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : multicycle_control_unit                                         |
// | Brief    : Multicycle MIPS-style control FSM; define MCU_IMM_LOGIC_EN to   |
// |            add the andi/ori immediate logic instructions.                  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module multicycle_control_unit #(
    parameter int ALU_CTRL_W   = 3,
    parameter int ILLEGAL_HALT = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [5:0]            op_code,
    input  logic [5:0]            funct,
    input  logic                  mem_ready,
    input  logic                  zero,
    output logic                  pc_en,
    output logic                  iord,
    output logic                  ir_write,
    output logic                  mem_w,
    output logic                  reg_w,
    output logic                  reg_dest,
    output logic                  mem_to_reg,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            pc_src,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic [3:0]            state,
    output logic                  illegal
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_IEXEC   = 4'd9,
        S_IWB     = 4'd10,
        S_JUMP    = 4'd11,
        S_ILLEGAL = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MCU_IMM_LOGIC_EN
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
`endif

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam state_t S_ON_ILLEGAL = (ILLEGAL_HALT != 0) ? S_ILLEGAL : S_FETCH;

    state_t     state_q;
    state_t     state_d;
    logic [2:0] alu_op_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_en      = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        mem_w      = 1'b0;
        reg_w      = 1'b0;
        reg_dest   = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        alu_op_d   = 3'b000;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                alu_src_b = 2'b01;
                alu_op_d  = ALU_ADD;
                // rst_n gating keeps the fetch strobes quiet while reset is held
                if (mem_ready) begin
                    ir_write = rst_n;
                    pc_en    = rst_n;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_op_d  = ALU_ADD;
                case (op_code)
                    OP_RTYPE:      state_d = S_EXEC;
                    OP_LW, OP_SW:  state_d = S_MEMADR;
                    OP_BEQ:        state_d = S_BRANCH;
                    OP_ADDI:       state_d = S_IEXEC;
`ifdef MCU_IMM_LOGIC_EN
                    OP_ANDI, OP_ORI: state_d = S_IEXEC;
`endif
                    OP_J:          state_d = S_JUMP;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_ON_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op_d  = ALU_ADD;
                state_d   = (op_code == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_w      = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                iord  = 1'b1;
                mem_w = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                state_d   = S_ALUWB;
                case (funct)
                    6'b100000: alu_op_d = ALU_ADD;
                    6'b100010: alu_op_d = ALU_SUB;
                    6'b100100: alu_op_d = ALU_AND;
                    6'b100101: alu_op_d = ALU_OR;
                    6'b101010: alu_op_d = ALU_SLT;
                    default: begin
                        // Skipping ALUWB is what suppresses the register write
                        illegal = 1'b1;
                        state_d = S_ON_ILLEGAL;
                    end
                endcase
            end
            S_ALUWB: begin
                reg_dest = 1'b1;
                reg_w    = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op_d  = ALU_SUB;
                pc_src    = 2'b01;
                pc_en     = zero;
                state_d   = S_FETCH;
            end
            S_IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op_d  = ALU_ADD;
`ifdef MCU_IMM_LOGIC_EN
                if (op_code == OP_ANDI) alu_op_d = ALU_AND;
                if (op_code == OP_ORI)  alu_op_d = ALU_OR;
`endif
                state_d = S_IWB;
            end
            S_IWB: begin
                reg_w   = 1'b1;
                state_d = S_FETCH;
            end
            S_JUMP: begin
                pc_src  = 2'b10;
                pc_en   = 1'b1;
                state_d = S_FETCH;
            end
            S_ILLEGAL: state_d = S_ILLEGAL;
            default:   state_d = S_FETCH;
        endcase
    end

    assign alu_control = ALU_CTRL_W'(alu_op_d);
    assign state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_multicycle_control_unit                                      |
// | Brief    : Scoreboard bench for multicycle_control_unit.                   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_multicycle_control_unit;

    // Flag vector: {pc_en, ir_write, iord, mem_w, reg_w, mem_to_reg, reg_dest,
    //               alu_src_a, alu_src_b[1:0], pc_src[1:0]}
    localparam logic [11:0] F_FETCH1 = 12'b1100_0000_0100;
    localparam logic [11:0] F_FETCH0 = 12'b0000_0000_0100;
    localparam logic [11:0] F_DEC    = 12'b0000_0000_1100;
    localparam logic [11:0] F_MADR   = 12'b0000_0001_1000;
    localparam logic [11:0] F_MRD    = 12'b0010_0000_0000;
    localparam logic [11:0] F_MWB    = 12'b0000_1100_0000;
    localparam logic [11:0] F_MWR    = 12'b0011_0000_0000;
    localparam logic [11:0] F_EXEC   = 12'b0000_0001_0000;
    localparam logic [11:0] F_AWB    = 12'b0000_1010_0000;
    localparam logic [11:0] F_BR1    = 12'b1000_0001_0001;
    localparam logic [11:0] F_BR0    = 12'b0000_0001_0001;
    localparam logic [11:0] F_IEX    = 12'b0000_0001_1000;
    localparam logic [11:0] F_IWB    = 12'b0000_1000_0000;
    localparam logic [11:0] F_JMP    = 12'b1000_0000_0010;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [2:0] A_ADD = 3'b010, A_SUB = 3'b110, A_OR = 3'b001, A_SLT = 3'b111;

    typedef struct packed {
        logic [3:0]  st;
        logic [11:0] fl;
        logic [2:0]  alu;
        logic        ill;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op_code, funct;
    logic       mem_ready, zero;
    logic       pc_en, iord, ir_write, mem_w, reg_w, reg_dest, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic [3:0] state;
    logic       illegal;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_cyc    = 0;

    multicycle_control_unit dut (
        .clk(clk), .rst_n(rst_n), .op_code(op_code), .funct(funct),
        .mem_ready(mem_ready), .zero(zero), .pc_en(pc_en), .iord(iord),
        .ir_write(ir_write), .mem_w(mem_w), .reg_w(reg_w), .reg_dest(reg_dest),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_src(pc_src), .alu_control(alu_control), .state(state), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] flags();
        return {pc_en, ir_write, iord, mem_w, reg_w, mem_to_reg, reg_dest,
                alu_src_a, alu_src_b, pc_src};
    endfunction

    // One clock cycle of stimulus plus the outputs required during that cycle
    task automatic cyc(input logic [5:0] op, input logic [5:0] fn, input logic mr,
                       input logic z, input logic [3:0] st, input logic [11:0] fl,
                       input logic [2:0] alu, input logic ill);
        @(posedge clk);
        #1;
        op_code   = op;
        funct     = fn;
        mem_ready = mr;
        zero      = z;
        sb.push_back('{st: st, fl: fl, alu: alu, ill: ill});
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            n_cyc++;
            chk($sformatf("cyc%0d.state", n_cyc), 32'(state), 32'(mon_e.st));
            chk($sformatf("cyc%0d.flags", n_cyc), 32'(flags()), 32'(mon_e.fl));
            chk($sformatf("cyc%0d.alu", n_cyc), 32'(alu_control), 32'(mon_e.alu));
            chk($sformatf("cyc%0d.illegal", n_cyc), 32'(illegal), 32'(mon_e.ill));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0; op_code = OP_LW; funct = 6'd0;
        #2;
        chk("rst.async.state", 32'(state), 32'd0);
        chk("rst.async.flags", 32'(flags()), 32'(F_FETCH0));
        chk("rst.async.alu", 32'(alu_control), 32'(A_ADD));
        chk("rst.async.illegal", 32'(illegal), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.held.state", 32'(state), 32'd0);
        chk("rst.held.flags", 32'(flags()), 32'(F_FETCH0));
        mem_ready = 1'b0;
        rst_n     = 1'b1;

        // lw, including one fetch wait cycle
        cyc(OP_LW, 6'd0, 1'b0, 1'b0, 4'd0, F_FETCH0, A_ADD, 1'b0);
        cyc(OP_LW, 6'd0, 1'b1, 1'b0, 4'd0, F_FETCH1, A_ADD, 1'b0);
        cyc(OP_LW, 6'd0, 1'b1, 1'b0, 4'd1, F_DEC,    A_ADD, 1'b0);
        cyc(OP_LW, 6'd0, 1'b1, 1'b0, 4'd2, F_MADR,   A_ADD, 1'b0);
        cyc(OP_LW, 6'd0, 1'b1, 1'b0, 4'd3, F_MRD,    3'd0,  1'b0);
        cyc(OP_LW, 6'd0, 1'b1, 1'b0, 4'd4, F_MWB,    3'd0,  1'b0);

        // sw with memory busy for three MEMWR cycles
        cyc(OP_SW, 6'd0, 1'b1, 1'b0, 4'd0, F_FETCH1, A_ADD, 1'b0);
        cyc(OP_SW, 6'd0, 1'b1, 1'b0, 4'd1, F_DEC,    A_ADD, 1'b0);
        cyc(OP_SW, 6'd0, 1'b1, 1'b0, 4'd2, F_MADR,   A_ADD, 1'b0);
        for (int i = 0; i < 3; i++)
            cyc(OP_SW, 6'd0, 1'b0, 1'b0, 4'd5, F_MWR, 3'd0, 1'b0);
        cyc(OP_SW, 6'd0, 1'b1, 1'b0, 4'd5, F_MWR,    3'd0,  1'b0);

        // beq taken, then not taken
        for (int t = 1; t >= 0; t--) begin
            cyc(OP_BEQ, 6'd0, 1'b1, t[0], 4'd0, F_FETCH1, A_ADD, 1'b0);
            cyc(OP_BEQ, 6'd0, 1'b1, t[0], 4'd1, F_DEC,    A_ADD, 1'b0);
            cyc(OP_BEQ, 6'd0, 1'b1, t[0], 4'd8, (t == 1) ? F_BR1 : F_BR0, A_SUB, 1'b0);
        end

        // R-type slt and sub
        cyc(OP_R, 6'b101010, 1'b1, 1'b0, 4'd0, F_FETCH1, A_ADD, 1'b0);
        cyc(OP_R, 6'b101010, 1'b1, 1'b0, 4'd1, F_DEC,    A_ADD, 1'b0);
        cyc(OP_R, 6'b101010, 1'b1, 1'b0, 4'd6, F_EXEC,   A_SLT, 1'b0);
        cyc(OP_R, 6'b101010, 1'b1, 1'b0, 4'd7, F_AWB,    3'd0,  1'b0);
        cyc(OP_R, 6'b100010, 1'b1, 1'b0, 4'd0, F_FETCH1, A_ADD, 1'b0);
        cyc(OP_R, 6'b100010, 1'b1, 1'b0, 4'd1, F_DEC,    A_ADD, 1'b0);
        cyc(OP_R, 6'b100010, 1'b1, 1'b0, 4'd6, F_EXEC,   A_SUB, 1'b0);
        cyc(OP_R, 6'b100010, 1'b1, 1'b0, 4'd7, F_AWB,    3'd0,  1'b0);

        // R-type with unknown funct: pulse, no ALUWB, straight back to fetch
        cyc(OP_R, 6'b000111, 1'b1, 1'b0, 4'd0, F_FETCH1, A_ADD, 1'b0);
        cyc(OP_R, 6'b000111, 1'b1, 1'b0, 4'd1, F_DEC,    A_ADD, 1'b0);
        cyc(OP_R, 6'b000111, 1'b1, 1'b0, 4'd6, F_EXEC,   3'd0,  1'b1);
        cyc(OP_R, 6'b000111, 1'b0, 1'b0, 4'd0, F_FETCH0, A_ADD, 1'b0);

        // ori
        cyc(OP_ORI, 6'd0, 1'b1, 1'b0, 4'd0, F_FETCH1, A_ADD, 1'b0);
`ifdef MCU_IMM_LOGIC_EN
        cyc(OP_ORI, 6'd0, 1'b1, 1'b0, 4'd1, F_DEC,    A_ADD, 1'b0);
        cyc(OP_ORI, 6'd0, 1'b1, 1'b0, 4'd9, F_IEX,    A_OR,  1'b0);
        cyc(OP_ORI, 6'd0, 1'b1, 1'b0, 4'd10, F_IWB,   3'd0,  1'b0);
`else
        cyc(OP_ORI, 6'd0, 1'b1, 1'b0, 4'd1, F_DEC,    A_ADD, 1'b1);
`endif
        cyc(OP_ORI, 6'd0, 1'b0, 1'b0, 4'd0, F_FETCH0, A_ADD, 1'b0);

        // lw aborted by reset while waiting in MEMRD
        cyc(OP_LW, 6'd0, 1'b1, 1'b0, 4'd0, F_FETCH1, A_ADD, 1'b0);
        cyc(OP_LW, 6'd0, 1'b1, 1'b0, 4'd1, F_DEC,    A_ADD, 1'b0);
        cyc(OP_LW, 6'd0, 1'b1, 1'b0, 4'd2, F_MADR,   A_ADD, 1'b0);
        cyc(OP_LW, 6'd0, 1'b0, 1'b0, 4'd3, F_MRD,    3'd0,  1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst.mid.state", 32'(state), 32'd0);
        chk("rst.mid.reg_w", 32'(reg_w), 32'd0);
        mem_ready = 1'b1;
        #1;
        chk("rst.mid.flags", 32'(flags()), 32'(F_FETCH0));
        @(negedge clk);
        chk("rst.mid.hold.state", 32'(state), 32'd0);
        chk("rst.mid.hold.reg_w", 32'(reg_w), 32'd0);
        mem_ready = 1'b0;
        rst_n     = 1'b1;

        // addi then j
        cyc(OP_ADDI, 6'd0, 1'b1, 1'b0, 4'd0, F_FETCH1, A_ADD, 1'b0);
        cyc(OP_ADDI, 6'd0, 1'b1, 1'b0, 4'd1, F_DEC,    A_ADD, 1'b0);
        cyc(OP_ADDI, 6'd0, 1'b1, 1'b0, 4'd9, F_IEX,    A_ADD, 1'b0);
        cyc(OP_ADDI, 6'd0, 1'b1, 1'b0, 4'd10, F_IWB,   3'd0,  1'b0);
        cyc(OP_J,    6'd0, 1'b1, 1'b0, 4'd0, F_FETCH1, A_ADD, 1'b0);
        cyc(OP_J,    6'd0, 1'b1, 1'b0, 4'd1, F_DEC,    A_ADD, 1'b0);
        cyc(OP_J,    6'd0, 1'b1, 1'b0, 4'd11, F_JMP,   3'd0,  1'b0);
        cyc(OP_J,    6'd0, 1'b0, 1'b0, 4'd0, F_FETCH0, A_ADD, 1'b0);

        repeat (2) @(negedge clk);
        #1;
        chk("scoreboard.drain", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
